umips_run_ctrl: RTL and testbench
=================================

Name: umips_run_ctrl

Overview:
Synthesizable run controller for the umips_top core, used by every core-level bench and on FPGA.
- Sequences the core reset from the system reset.
- Counts cycles and retired instructions.
- Detects program end through a magic store ("tohost") or a branch-to-self halt.
- Raises a watchdog timeout.
- Benches finish on `done` instead of a fixed delay.

Parameters:
- RESET_CYCLES, 2: cycles `core_reset` is held high after `reset` deasserts; minimum 1.
- TIMEOUT_CYCLES, 50: RUN cycles before timeout; 0 disables the watchdog.
- HALT_REPEAT, 4: consecutive retirements of the same PC that count as a halt; 0 disables halt detection.
- PC_WIDTH, 32: PC width.
- DATA_WIDTH, 32: store data/address width.
- CNT_WIDTH, 32: counter width.
- TOHOST_ADDR, 32'h0000_FFFC: magic store address.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high system reset
- wb_valid  in  1  an instruction retires this cycle
- wb_pc  in  PC_WIDTH  PC of the retiring instruction
- mem_we  in  1  data-memory write strobe
- mem_addr  in  DATA_WIDTH  data-memory address
- mem_wdata  in  DATA_WIDTH  data-memory write data
- core_reset  out  1  reset to umips_top
- running  out  1  controller in RUN
- done  out  1  sticky end-of-run flag
- pass  out  1  valid when done
- fail  out  1  valid when done
- timeout  out  1  valid when done; watchdog caused the end
- exit_code  out  DATA_WIDTH  tohost value; 0 for halt or timeout
- cycle_count  out  CNT_WIDTH  RUN cycles elapsed
- instret_count  out  CNT_WIDTH  retired instructions
- stall_count  out  CNT_WIDTH  RUN cycles with no retirement (see Optional Feature)

Behaviour:
- One clock, `clk`. Reset is synchronous and active-high on `reset`. All flops are updated only on the rising edge of `clk`.
- Reset values:
  - `core_reset` = 1.
  - `running`, `done`, `pass`, `fail`, `timeout` = 0.
  - `exit_code` and all counters = 0.
  - State = HOLD, hold counter = 0.
- HOLD:
  - `core_reset` = 1 and the hold counter increments each cycle.
  - When it reaches RESET_CYCLES-1, move to RUN on the next edge. `core_reset` therefore stays high for exactly RESET_CYCLES cycles after `reset` falls.
- RUN:
  - `core_reset` = 0, `running` = 1.
  - `cycle_count` increments every cycle.
  - `instret_count` increments when `wb_valid`=1.
- Inputs are ignored in HOLD and DONE; counters freeze in DONE.
- End conditions, evaluated in RUN only. The first one true moves to DONE on that edge, with priority tohost > halt > timeout:
  - Tohost: `mem_we`=1 and `mem_addr`==TOHOST_ADDR.
    - `exit_code` = `mem_wdata`.
    - `pass` = (`mem_wdata`==1), `fail` = !`pass`.
  - Halt:
    - A repeat counter increments when `wb_valid`=1 and `wb_pc` equals the last retired PC.
    - It resets to 1 when `wb_valid`=1 with a different PC.
    - It holds on cycles with `wb_valid`=0.
    - When it reaches HALT_REPEAT: `pass`=1, `exit_code`=0.
  - Timeout: `cycle_count`==TIMEOUT_CYCLES-1 this cycle, TIMEOUT_CYCLES≠0.
    - `timeout`=1, `fail`=1.
- DONE:
  - `done`, `pass`, `fail`, `timeout`, `exit_code` are sticky.
  - `core_reset` reasserts so the core stops.
  - Leave DONE only via `reset`.
- Reset mid-run: `reset` at any cycle returns to HOLD with reset values on the next edge. Nothing is preserved.
- Counters wrap modulo 2^CNT_WIDTH; a wrap does not end the run.
- `pass` and `fail` are never both 1.

Optional Feature:
- Macro: UMIPS_RUN_CTRL_STALL_CNT_EN.
- Defined: `stall_count` increments each RUN cycle with `wb_valid`=0, and resets and freezes like the other counters.
- Undefined: no stall counter flops are built and `stall_count` is tied to 0.

Decomposition:
- Package `umips_run_pkg` holds:
  - State enum `run_state_t` {HOLD, RUN, DONE}.
  - Default constants for TOHOST_ADDR and the pass code (1).
  - Enum `end_cause_t` {NONE, TOHOST, HALT, TIMEOUT} for bench reporting.
- Sub-module `umips_halt_detect` contains the last-PC register plus the repeat counter, and outputs a `halt` pulse. All other logic stays inline.

Test Plan:
- Reset sequencing: `reset` high 1 cycle, RESET_CYCLES=2 → `core_reset` high for exactly 2 cycles after `reset` falls; `running` rises on cycle 3.
- Tohost pass: store 1 to 0xFFFC at RUN cycle 10 → `done`=1, `pass`=1, `exit_code`=1 next edge; `cycle_count` frozen at 11; `core_reset`=1.
- Tohost fail plus priority: store 7 to 0xFFFC in the same cycle as the HALT_REPEAT-th retirement of PC 0x40 → `fail`=1, `exit_code`=7, `pass`=0.
- Halt with gaps: PC 0x40 retired 4 times with `wb_valid`=0 bubbles in between → `done`, `pass`=1 on the 4th retirement. The sequence 0x40, 0x40, 0x44, 0x40 does not halt.
- Timeout: no retirements, TIMEOUT_CYCLES=50 → `done`, `timeout`, `fail` on RUN cycle 50; `instret_count`=0. With UMIPS_RUN_CTRL_STALL_CNT_EN defined, `stall_count`=50; undefined, `stall_count`=0.
- Reset mid-run: assert `reset` at RUN cycle 20, then again while in DONE → all outputs return to reset values next edge, and a new HOLD/RUN sequence completes normally.

Source files
------------

// File: rtl/umips_run_pkg.sv
// Shared types and default constants for the umips run controller.
package umips_run_pkg;

    typedef enum logic [1:0] {HOLD, RUN, DONE} run_state_t;

    typedef enum logic [1:0] {NONE, TOHOST, HALT, TIMEOUT} end_cause_t;

    localparam logic [31:0] TOHOST_ADDR_DEF = 32'h0000_FFFC;
    localparam int          PASS_CODE       = 1;

endpackage

// File: rtl/umips_halt_detect.sv
// Branch-to-self halt detector: counts back-to-back retirements of the same PC
// (bubbles in between do not break the streak) and pulses halt on the Nth one.
module umips_halt_detect #(
    parameter int PC_WIDTH    = 32,
    parameter int HALT_REPEAT = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                wb_valid,
    input  logic [PC_WIDTH-1:0] wb_pc,
    output logic                halt
);

    localparam int CW = $clog2(HALT_REPEAT + 2) + 1;

    logic [PC_WIDTH-1:0] last_pc;
    logic [CW-1:0]       rep_cnt;
    logic [CW-1:0]       rep_next;

    // A zero count means no PC has retired yet, so last_pc is not meaningful.
    always_comb begin
        rep_next = CW'(1);
        if (rep_cnt != '0 && wb_pc == last_pc)
            rep_next = rep_cnt + 1'b1;
    end

    assign halt = (HALT_REPEAT != 0) && en && wb_valid && (rep_next == CW'(HALT_REPEAT));

    always_ff @(posedge clk) begin
        if (reset) begin
            last_pc <= '0;
            rep_cnt <= '0;
        end else if (en && wb_valid) begin
            last_pc <= wb_pc;
            rep_cnt <= rep_next;
        end
    end

endmodule

// File: rtl/umips_run_ctrl.sv
// Run controller for umips_top: reset sequencing, counters, end-of-run detection.
// Optional stall counter built when UMIPS_RUN_CTRL_STALL_CNT_EN is defined.
module umips_run_ctrl
    import umips_run_pkg::*;
#(
    parameter int RESET_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 50,
    parameter int HALT_REPEAT    = 4,
    parameter int PC_WIDTH       = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int CNT_WIDTH      = 32,
    parameter logic [DATA_WIDTH-1:0] TOHOST_ADDR = DATA_WIDTH'(TOHOST_ADDR_DEF)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wb_valid,
    input  logic [PC_WIDTH-1:0]   wb_pc,
    input  logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  core_reset,
    output logic                  running,
    output logic                  done,
    output logic                  pass,
    output logic                  fail,
    output logic                  timeout,
    output logic [DATA_WIDTH-1:0] exit_code,
    output logic [CNT_WIDTH-1:0]  cycle_count,
    output logic [CNT_WIDTH-1:0]  instret_count,
    output logic [CNT_WIDTH-1:0]  stall_count
);

    localparam int HW = $clog2(RESET_CYCLES + 1);

    run_state_t    state, state_next;
    logic [HW-1:0] hold_cnt;
    logic          halt, hit_tohost, hit_timeout, tohost_pass;

    assign running     = (state == RUN);
    assign core_reset  = (state != RUN);
    assign done        = (state == DONE);
    assign hit_tohost  = mem_we && (mem_addr == TOHOST_ADDR);
    assign tohost_pass = (mem_wdata == DATA_WIDTH'(PASS_CODE));
    assign hit_timeout = (TIMEOUT_CYCLES != 0) &&
                         (cycle_count == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

    umips_halt_detect #(
        .PC_WIDTH    (PC_WIDTH),
        .HALT_REPEAT (HALT_REPEAT)
    ) u_halt (
        .clk      (clk),
        .reset    (reset),
        .en       (running),
        .wb_valid (wb_valid),
        .wb_pc    (wb_pc),
        .halt     (halt)
    );

    always_comb begin
        state_next = state;
        case (state)
            HOLD:    if (hold_cnt == HW'(RESET_CYCLES - 1)) state_next = RUN;
            RUN:     if (hit_tohost || halt || hit_timeout) state_next = DONE;
            default: state_next = state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= HOLD;
            hold_cnt      <= '0;
            pass          <= 1'b0;
            fail          <= 1'b0;
            timeout       <= 1'b0;
            exit_code     <= '0;
            cycle_count   <= '0;
            instret_count <= '0;
        end else begin
            state <= state_next;
            if (state == HOLD)
                hold_cnt <= hold_cnt + 1'b1;
            if (running) begin
                cycle_count <= cycle_count + 1'b1;
                if (wb_valid)
                    instret_count <= instret_count + 1'b1;
                // Priority tohost > halt > timeout; the end edge still counts.
                if (hit_tohost) begin
                    exit_code <= mem_wdata;
                    pass      <= tohost_pass;
                    fail      <= !tohost_pass;
                end else if (halt) begin
                    pass <= 1'b1;
                end else if (hit_timeout) begin
                    timeout <= 1'b1;
                    fail    <= 1'b1;
                end
            end
        end
    end

`ifdef UMIPS_RUN_CTRL_STALL_CNT_EN
    logic [CNT_WIDTH-1:0] stall_q;

    always_ff @(posedge clk) begin
        if (reset)
            stall_q <= '0;
        else if (running && !wb_valid)
            stall_q <= stall_q + 1'b1;
    end

    assign stall_count = stall_q;
`else
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_umips_run_ctrl.sv
// Directed self-checking bench for umips_run_ctrl (default parameters).
module tb_umips_run_ctrl;
    import umips_run_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid;
    logic [31:0] wb_pc;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        core_reset, running, done, pass, fail, timeout;
    logic [31:0] exit_code, cycle_count, instret_count, stall_count;

    int checks   = 0;
    int failures = 0;
    end_cause_t cause;

    umips_run_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .wb_valid      (wb_valid),
        .wb_pc         (wb_pc),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .core_reset    (core_reset),
        .running       (running),
        .done          (done),
        .pass          (pass),
        .fail          (fail),
        .timeout       (timeout),
        .exit_code     (exit_code),
        .cycle_count   (cycle_count),
        .instret_count (instret_count),
        .stall_count   (stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cause %s)", tag, got, exp, cause.name());
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb_valid  = 1'b0;
        wb_pc     = '0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".core_reset"}, core_reset, 1);
        chk({tag, ".running"},    running, 0);
        chk({tag, ".done"},       done, 0);
        chk({tag, ".pass"},       pass, 0);
        chk({tag, ".fail"},       fail, 0);
        chk({tag, ".timeout"},    timeout, 0);
        chk({tag, ".exit_code"},  exit_code, 0);
        chk({tag, ".cycle"},      cycle_count, 0);
        chk({tag, ".instret"},    instret_count, 0);
        chk({tag, ".stall"},      stall_count, 0);
    endtask

    // Reset for one cycle, then wait out the two HOLD cycles into RUN.
    task automatic start_run();
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        step();
    endtask

    initial begin
        logic [31:0] stall_exp;
        cause = NONE;
        idle();

        // Reset sequencing
        reset = 1'b1;
        step();
        chk_reset_vals("rst");
        reset = 1'b0;
        step();
        chk("hold1.core_reset", core_reset, 1);
        chk("hold1.running", running, 0);
        step();
        chk("run.core_reset", core_reset, 0);
        chk("run.running", running, 1);
        chk("run.cycle0", cycle_count, 0);

        // Tohost pass at cycle_count==10, retiring distinct PCs every cycle
        cause = TOHOST;
        start_run();
        for (int i = 0; i < 10; i++) begin
            wb_valid = 1'b1;
            wb_pc    = 32'h100 + 32'(i * 4);
            step();
        end
        chk("pass.cycle10", cycle_count, 10);
        chk("pass.not_done", done, 0);
        wb_pc     = 32'h200;
        mem_we    = 1'b1;
        mem_addr  = 32'h0000_FFFC;
        mem_wdata = 32'd1;
        step();
        chk("pass.done", done, 1);
        chk("pass.pass", pass, 1);
        chk("pass.fail", fail, 0);
        chk("pass.exit", exit_code, 1);
        chk("pass.cycle", cycle_count, 11);
        chk("pass.instret", instret_count, 11);
        chk("pass.core_reset", core_reset, 1);
        // Inputs in DONE are ignored, outputs sticky
        mem_wdata = 32'd9;
        step();
        idle();
        step();
        chk("pass.sticky_exit", exit_code, 1);
        chk("pass.sticky_pass", pass, 1);
        chk("pass.frozen_cycle", cycle_count, 11);
        chk("pass.frozen_instret", instret_count, 11);

        // Tohost fail beats halt in the same cycle
        cause = TOHOST;
        start_run();
        for (int i = 0; i < 3; i++) begin
            wb_valid = 1'b1;
            wb_pc    = 32'h40;
            step();
        end
        chk("prio.not_done", done, 0);
        mem_we    = 1'b1;
        mem_addr  = 32'h0000_FFFC;
        mem_wdata = 32'd7;
        step();
        idle();
        chk("prio.done", done, 1);
        chk("prio.fail", fail, 1);
        chk("prio.pass", pass, 0);
        chk("prio.exit", exit_code, 7);
        chk("prio.timeout", timeout, 0);

        // Halt with bubbles: v b v b b v b v
        cause = HALT;
        start_run();
        begin
            logic [7:0] pat;
            pat = 8'b1010_0101;  // LSB first: v,b,v,b,b,v,b,v
            for (int i = 0; i < 8; i++) begin
                wb_valid = pat[i];
                wb_pc    = 32'h40;
                if (i == 7) chk("halt.not_done_early", done, 0);
                step();
            end
        end
        idle();
        chk("halt.done", done, 1);
        chk("halt.pass", pass, 1);
        chk("halt.fail", fail, 0);
        chk("halt.exit", exit_code, 0);
        chk("halt.instret", instret_count, 4);
        chk("halt.cycle", cycle_count, 8);
`ifdef UMIPS_RUN_CTRL_STALL_CNT_EN
        stall_exp = 32'd4;
`else
        stall_exp = 32'd0;
`endif
        chk("halt.stall", stall_count, stall_exp);

        // 0x40,0x40,0x44,0x40 must not halt
        cause = NONE;
        start_run();
        begin
            logic [31:0] seq [4];
            seq = '{32'h40, 32'h40, 32'h44, 32'h40};
            for (int i = 0; i < 4; i++) begin
                wb_valid = 1'b1;
                wb_pc    = seq[i];
                step();
            end
        end
        idle();
        step();
        step();
        chk("nohalt.done", done, 0);
        chk("nohalt.running", running, 1);
        chk("nohalt.instret", instret_count, 4);

        // Watchdog timeout with no retirements
        cause = TIMEOUT;
        start_run();
        for (int i = 0; i < 49; i++) step();
        chk("to.not_done49", done, 0);
        chk("to.cycle49", cycle_count, 49);
        step();
        chk("to.done", done, 1);
        chk("to.timeout", timeout, 1);
        chk("to.fail", fail, 1);
        chk("to.pass", pass, 0);
        chk("to.exit", exit_code, 0);
        chk("to.cycle", cycle_count, 50);
        chk("to.instret", instret_count, 0);
`ifdef UMIPS_RUN_CTRL_STALL_CNT_EN
        stall_exp = 32'd50;
`else
        stall_exp = 32'd0;
`endif
        chk("to.stall", stall_count, stall_exp);

        // Reset while in DONE
        cause = NONE;
        reset = 1'b1;
        step();
        chk_reset_vals("rst_done");

        // Reset mid-run at cycle 20, then a fresh run ending in a failing tohost
        reset = 1'b0;
        step();
        step();
        for (int i = 0; i < 20; i++) begin
            wb_valid = 1'b1;
            wb_pc    = 32'h300 + 32'(i * 4);
            step();
        end
        chk("mid.cycle20", cycle_count, 20);
        idle();
        reset = 1'b1;
        step();
        chk_reset_vals("rst_mid");
        reset = 1'b0;
        step();
        chk("mid.hold", core_reset, 1);
        step();
        chk("mid.running", running, 1);
        cause = TOHOST;
        mem_we    = 1'b1;
        mem_addr  = 32'h0000_FFFC;
        mem_wdata = 32'hDEAD;
        step();
        idle();
        chk("mid.done", done, 1);
        chk("mid.fail", fail, 1);
        chk("mid.pass", pass, 0);
        chk("mid.exit", exit_code, 32'hDEAD);
        chk("mid.cycle", cycle_count, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
